// File: rtl/deparser_pkg.sv
// Shared definitions for the egress deparser: stream tags, action bits and FSM states.
package deparser_pkg;

    localparam int WORD_W = 134;

    localparam logic [1:0] TAG_HEAD     = 2'b01;
    localparam logic [1:0] TAG_BODY     = 2'b11;
    localparam logic [1:0] TAG_PKT_END  = 2'b10;
    localparam logic [1:0] TAG_META_END = 2'b00;

    // Bit positions inside the action byte carried in meta word 0 [127:120].
    localparam int ACT_REWRITE = 0;
    localparam int ACT_DROP    = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_META,
        S_WAIT_HEAD,
        S_PASS,
        S_DISCARD,
        S_FLUSH
    } state_t;

    function automatic logic [1:0] tagOf(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: 2];
    endfunction

endpackage

// File: rtl/deparser_skid.sv
// Two-entry valid/ready skid FIFO; the head register drives the output directly,
// so a stalled output holds its value and push+pop on a full buffer keeps order.
module deparser_skid
    import deparser_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data,
    input  logic              i_ready
);

    logic [WORD_W-1:0] r_head;
    logic [WORD_W-1:0] r_tail;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign w_pop   = (r_count != 2'd0) && i_ready;
    assign w_push  = i_valid && ((r_count != 2'd2) || w_pop);
    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_data;
                    else                 r_tail <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/deparser.sv
// Egress deparser: strips the metadata words that precede each packet and applies
// the action byte (drop or header-field rewrite) before handing words to the skid.
module deparser
    import deparser_pkg::*;
#(
    parameter int NUM_OF_META = 3,
    parameter int RW_HI       = 127,
    parameter int RW_LO       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              metadata_in_valid,
    input  logic [WORD_W-1:0] metadata_in,
    output logic              ready_out,
    output logic              metadata_out_valid,
    output logic [WORD_W-1:0] metadata_out,
    input  logic              ready_in,
    output logic [31:0]       pkt_cnt,
    output logic [31:0]       drop_cnt,
    output logic [31:0]       err_cnt
);

    // Index of the last meta word; the 00 tag is legal only there.
    localparam logic [3:0] META_LAST = 4'(NUM_OF_META - 1);

    state_t             r_state;
    logic [3:0]         r_metaIdx;
    logic [1:0]         r_action;
    logic [RW_HI:RW_LO] r_rwField;

    logic              w_skidReady;
    logic              w_accept;
    logic [1:0]        w_tag;
    logic              w_push;
    logic [WORD_W-1:0] w_pushData;
    logic [WORD_W-1:0] w_headWord;

    assign w_accept  = metadata_in_valid && w_skidReady;
    assign ready_out = w_skidReady;
    assign w_tag     = tagOf(metadata_in);

    always_comb begin
        w_headWord = metadata_in;
        if (r_action[ACT_REWRITE]) w_headWord[RW_HI:RW_LO] = r_rwField;
    end

    // Words are pushed in the same cycle they are accepted, giving one cycle of latency.
    always_comb begin
        w_push     = 1'b0;
        w_pushData = metadata_in;
        if (w_accept) begin
            case (r_state)
                S_WAIT_HEAD: begin
                    if ((w_tag == TAG_HEAD || w_tag == TAG_PKT_END) && !r_action[ACT_DROP]) begin
                        w_push     = 1'b1;
                        w_pushData = w_headWord;
                    end
                end
                S_PASS:  w_push = (w_tag != TAG_HEAD);
                default: w_push = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_metaIdx <= 4'd0;
            r_action  <= 2'b00;
            r_rwField <= '0;
            pkt_cnt   <= 32'd0;
            drop_cnt  <= 32'd0;
            err_cnt   <= 32'd0;
        end else if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (w_tag == TAG_HEAD) begin
                        r_action  <= metadata_in[121:120];
                        r_metaIdx <= 4'd1;
                        r_state   <= S_READ_META;
                    end else begin
                        err_cnt <= err_cnt + 32'd1;
                    end
                end
                S_READ_META: begin
                    if (r_metaIdx == 4'd1) r_rwField <= metadata_in[RW_HI:RW_LO];
                    if (w_tag == TAG_META_END) begin
                        r_state <= S_WAIT_HEAD;
                        if (r_metaIdx != META_LAST) err_cnt <= err_cnt + 32'd1;
                    end else if (r_metaIdx == META_LAST) begin
                        err_cnt <= err_cnt + 32'd1;
                        r_state <= S_FLUSH;
                    end else begin
                        r_metaIdx <= r_metaIdx + 4'd1;
                    end
                end
                S_WAIT_HEAD: begin
                    if (w_tag == TAG_HEAD) begin
                        r_state <= r_action[ACT_DROP] ? S_DISCARD : S_PASS;
                    end else if (w_tag == TAG_PKT_END) begin
                        if (r_action[ACT_DROP]) drop_cnt <= drop_cnt + 32'd1;
                        else                    pkt_cnt  <= pkt_cnt + 32'd1;
                        r_state <= S_IDLE;
                    end else begin
                        err_cnt <= err_cnt + 32'd1;
                        r_state <= S_FLUSH;
                    end
                end
                S_PASS: begin
                    if (w_tag == TAG_PKT_END) begin
                        pkt_cnt <= pkt_cnt + 32'd1;
                        r_state <= S_IDLE;
                    end else if (w_tag == TAG_HEAD) begin
                        err_cnt <= err_cnt + 32'd1;
                        r_state <= S_FLUSH;
                    end
                end
                S_DISCARD: begin
                    if (w_tag == TAG_PKT_END) begin
                        drop_cnt <= drop_cnt + 32'd1;
                        r_state  <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (w_tag == TAG_PKT_END) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    deparser_skid u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_push),
        .i_data  (w_pushData),
        .o_ready (w_skidReady),
        .o_valid (metadata_out_valid),
        .o_data  (metadata_out),
        .i_ready (ready_in)
    );

endmodule

// File: tb/tb_deparser.sv
// Bench for deparser: directed scenarios plus randomized packets, all checked
// against a packet-level reference model that builds the expected output stream.
module tb_deparser;

    localparam int NUM_OF_META = 3;
    localparam int RW_HI       = 127;
    localparam int RW_LO       = 32;

    typedef logic [133:0] word_t;

    logic        clk;
    logic        reset;
    logic        metadata_in_valid;
    word_t       metadata_in;
    logic        ready_out;
    logic        metadata_out_valid;
    word_t       metadata_out;
    logic        ready_in;
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;
    logic [31:0] err_cnt;

    int    checks = 0;
    int    errors = 0;
    int    expPkt;
    int    expDrop;
    int    expErr;
    word_t stimQ[$];
    word_t expQ[$];
    word_t gotQ[$];
    bit    sendDone;

    deparser #(
        .NUM_OF_META (NUM_OF_META),
        .RW_HI       (RW_HI),
        .RW_LO       (RW_LO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .metadata_in_valid  (metadata_in_valid),
        .metadata_in        (metadata_in),
        .ready_out          (ready_out),
        .metadata_out_valid (metadata_out_valid),
        .metadata_out       (metadata_out),
        .ready_in           (ready_in),
        .pkt_cnt            (pkt_cnt),
        .drop_cnt           (drop_cnt),
        .err_cnt            (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change only at negedges, so the handshake of the next posedge is visible here.
    always begin
        @(negedge clk);
        #1;
        if (!reset && metadata_out_valid && ready_in) gotQ.push_back(metadata_out);
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input word_t got, input word_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic word_t mk(input logic [1:0] tag, input logic [127:0] data);
        logic [3:0] rsvd;
        rsvd = 4'($urandom());
        return {tag, rsvd, data};
    endfunction

    // Expected header: bits RW_LO..RW_HI come from meta word 1, everything else from the packet.
    function automatic word_t rewriteModel(input word_t w0, input logic [127:0] meta1);
        word_t mask;
        mask = '0;
        for (int b = RW_LO; b <= RW_HI; b++) mask[b] = 1'b1;
        return (w0 & ~mask) | ({6'b0, meta1} & mask);
    endfunction

    // Appends one well-formed packet to the stimulus and its expected effect to the model.
    task automatic addPacket(input logic [7:0] action, input int len,
                             input logic [127:0] meta1Data, input logic [127:0] word0Data);
        logic [127:0] d;
        word_t        w;
        d = rnd128();
        d[127:120] = action;
        stimQ.push_back(mk(2'b01, d));
        for (int i = 1; i < NUM_OF_META; i++) begin
            d = (i == 1) ? meta1Data : rnd128();
            stimQ.push_back(mk((i == NUM_OF_META - 1) ? 2'b00 : 2'b11, d));
        end
        for (int i = 0; i < len; i++) begin
            if (i == 0) w = mk(2'b01, word0Data);
            else        w = mk((i == len - 1) ? 2'b10 : 2'b11, rnd128());
            stimQ.push_back(w);
            if (!action[1]) expQ.push_back((i == 0 && action[0]) ? rewriteModel(w, meta1Data) : w);
        end
        if (action[1]) expDrop++;
        else           expPkt++;
    endtask

    task automatic sendWord(input word_t w);
        int guard;
        guard = 0;
        @(negedge clk);
        metadata_in       = w;
        metadata_in_valid = 1'b1;
        while (!ready_out && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) checkValue("ready_out timeout", 32'(ready_out), 32'd1);
        @(posedge clk);
    endtask

    task automatic applyStimulus();
        while (stimQ.size() > 0) sendWord(stimQ.pop_front());
        @(negedge clk);
        metadata_in_valid = 1'b0;
    endtask

    task automatic drainCheck(input string tag);
        int guard;
        guard = 0;
        while (gotQ.size() < expQ.size() && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        checkValue({tag, " word count"}, 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
            checkOutput($sformatf("%s word %0d", tag, i), gotQ[i], expQ[i]);
        checkValue({tag, " pkt_cnt"},  pkt_cnt,  32'(expPkt));
        checkValue({tag, " drop_cnt"}, drop_cnt, 32'(expDrop));
        checkValue({tag, " err_cnt"},  err_cnt,  32'(expErr));
    endtask

    task automatic clearQueues();
        gotQ.delete();
        expQ.delete();
    endtask

    initial begin
        logic [127:0] d;
        word_t        w;
        word_t        held;
        logic [7:0]   act;

        reset             = 1'b1;
        metadata_in_valid = 1'b0;
        metadata_in       = '0;
        ready_in          = 1'b1;
        expPkt            = 0;
        expDrop           = 0;
        expErr            = 0;

        repeat (3) @(negedge clk);
        checkValue("reset out_valid", 32'(metadata_out_valid), 32'd0);
        checkOutput("reset metadata_out", metadata_out, '0);
        checkValue("reset ready_out", 32'(ready_out), 32'd1);
        checkValue("reset pkt_cnt", pkt_cnt, 32'd0);
        checkValue("reset drop_cnt", drop_cnt, 32'd0);
        checkValue("reset err_cnt", err_cnt, 32'd0);
        reset = 1'b0;

        $display("[TB] test 1: plain pass-through");
        addPacket(8'h00, 4, rnd128(), rnd128());
        for (int i = 0; i < NUM_OF_META + 4; i++) begin
            sendWord(stimQ.pop_front());
            if (i == NUM_OF_META) begin
                @(negedge clk);
                metadata_in_valid = 1'b0;
                checkValue("t1 latency valid", 32'(metadata_out_valid), 32'd1);
                checkOutput("t1 latency word0", metadata_out, expQ[0]);
            end
        end
        @(negedge clk);
        metadata_in_valid = 1'b0;
        drainCheck("t1");
        clearQueues();

        $display("[TB] test 2: header rewrite");
        addPacket(8'h01, 3, 128'hAABBCCDD_EEFF0011_22334455_66778899, 128'h0);
        applyStimulus();
        drainCheck("t2");
        w = (gotQ.size() > 0) ? gotQ[0] : '0;
        checkOutput("t2 rewrite field", {38'b0, w[127:32]}, {38'b0, 96'hAABBCCDD_EEFF0011_22334455});
        checkValue("t2 low bits", w[31:0], 32'h0);
        checkValue("t2 head tag", 32'(w[133:132]), 32'd1);
        clearQueues();

        $display("[TB] test 3: drop then pass");
        addPacket(8'h02, 5, rnd128(), rnd128());
        addPacket(8'h00, 3, rnd128(), rnd128());
        applyStimulus();
        drainCheck("t3");
        clearQueues();

        $display("[TB] test 4: output stall");
        addPacket(8'h00, 12, rnd128(), rnd128());
        fork
            applyStimulus();
            begin
                repeat (6) @(negedge clk);
                ready_in = 1'b0;
                @(negedge clk);
                held = metadata_out;
                for (int i = 0; i < 9; i++) begin
                    @(negedge clk);
                    checkValue("t4 stall valid", 32'(metadata_out_valid), 32'd1);
                    checkOutput("t4 stall hold", metadata_out, held);
                end
                checkValue("t4 ready_out full", 32'(ready_out), 32'd0);
                ready_in = 1'b1;
            end
        join
        drainCheck("t4");
        clearQueues();

        $display("[TB] test 5: framing errors");
        d = rnd128();
        d[127:120] = 8'h00;
        stimQ.push_back(mk(2'b01, d));
        repeat (4) stimQ.push_back(mk(2'b11, rnd128()));
        stimQ.push_back(mk(2'b01, rnd128()));
        stimQ.push_back(mk(2'b11, rnd128()));
        stimQ.push_back(mk(2'b10, rnd128()));
        expErr++;
        applyStimulus();
        drainCheck("t5a");
        clearQueues();

        d = rnd128();
        d[127:120] = 8'h00;
        stimQ.push_back(mk(2'b01, d));
        stimQ.push_back(mk(2'b11, rnd128()));
        stimQ.push_back(mk(2'b00, rnd128()));
        w = mk(2'b01, rnd128());
        stimQ.push_back(w);
        expQ.push_back(w);
        w = mk(2'b11, rnd128());
        stimQ.push_back(w);
        expQ.push_back(w);
        stimQ.push_back(mk(2'b01, rnd128()));
        stimQ.push_back(mk(2'b11, rnd128()));
        stimQ.push_back(mk(2'b10, rnd128()));
        expErr++;
        addPacket(8'h00, 3, rnd128(), rnd128());
        applyStimulus();
        drainCheck("t5b");
        clearQueues();

        $display("[TB] test 6: reset during packet");
        addPacket(8'h00, 6, rnd128(), rnd128());
        for (int i = 0; i < NUM_OF_META + 2; i++) sendWord(stimQ.pop_front());
        @(negedge clk);
        metadata_in_valid = 1'b0;
        reset             = 1'b1;
        @(negedge clk);
        checkValue("t6 out_valid", 32'(metadata_out_valid), 32'd0);
        checkOutput("t6 metadata_out", metadata_out, '0);
        checkValue("t6 ready_out", 32'(ready_out), 32'd1);
        checkValue("t6 pkt_cnt", pkt_cnt, 32'd0);
        checkValue("t6 err_cnt", err_cnt, 32'd0);
        reset = 1'b0;
        stimQ.delete();
        clearQueues();
        expPkt  = 0;
        expDrop = 0;
        expErr  = 0;
        addPacket(8'h01, 4, rnd128(), rnd128());
        applyStimulus();
        drainCheck("t6");
        clearQueues();

        $display("[TB] random packets with output throttling");
        for (int p = 0; p < 25; p++) begin
            act = 8'($urandom());
            addPacket(act, int'($urandom_range(2, 7)), rnd128(), rnd128());
        end
        sendDone = 1'b0;
        fork
            begin
                applyStimulus();
                sendDone = 1'b1;
            end
            begin
                while (!sendDone) begin
                    @(negedge clk);
                    ready_in = ($urandom_range(0, 3) != 0);
                end
                ready_in = 1'b1;
            end
        join
        drainCheck("rand");
        clearQueues();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
